reuleaux_draw: RTL

Parametrised shape-drawing engine for the VGA adapter path that traces a full circle or a complete Reuleaux triangle (all three arcs) with the midpoint circle algorithm. Each clock it emits one candidate pixel, with the plot strobe qualified by screen bounds and per-arc clipping. It sits between the top-level control and the VGA adapter's plot port. It generalises screen size, coordinate width and colour depth, and adds a circle/Reuleaux mode select.

---
 rtl/vga_draw_pkg.sv | 25 ++
 rtl/octant_point.sv | 63 ++++++
 rtl/reuleaux_draw.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA shape-drawing engines.
package vga_draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ARC_INIT,
    S_PLOT,
    S_STEP,
    S_DONE
  } draw_state_t;

  // Equilateral triangle proportions: apex height and base offset from centre, scaled by K_DEN.
  localparam int K_HT  = 577;
  localparam int K_HB  = 289;
  localparam int K_DEN = 1000;

  typedef enum logic [1:0] {
    CLIP_NONE,
    CLIP_BOTTOM,
    CLIP_RIGHT,
    CLIP_LEFT
  } arc_clip_t;

endpackage

// File: rtl/octant_point.sv
// Reflects a midpoint-circle offset into one octant and qualifies the
// resulting pixel against the screen and the active arc's clip window.
module octant_point
  import vga_draw_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int IW       = 12
) (
  input  logic signed [IW-1:0] acx,
  input  logic signed [IW-1:0] acy,
  input  logic signed [IW-1:0] ox,
  input  logic signed [IW-1:0] oy,
  input  logic        [2:0]    oct,
  input  arc_clip_t            clip,
  input  logic signed [IW-1:0] cx,
  input  logic signed [IW-1:0] ybot,
  input  logic signed [IW-1:0] xl,
  input  logic signed [IW-1:0] xr,
  output logic        [XW-1:0] px,
  output logic        [YW-1:0] py,
  output logic                 plot_ok
);

  localparam logic signed [IW-1:0] X_LIM = IW'(SCREEN_W);
  localparam logic signed [IW-1:0] Y_LIM = IW'(SCREEN_H);

  logic signed [IW-1:0] dx, dy, x, y;
  logic                 on_screen, clip_ok;

  always_comb begin
    dx = ox;
    dy = oy;
    case (oct)
      3'd0: begin dx =  ox; dy =  oy; end
      3'd1: begin dx =  oy; dy =  ox; end
      3'd2: begin dx = -ox; dy =  oy; end
      3'd3: begin dx = -oy; dy =  ox; end
      3'd4: begin dx = -ox; dy = -oy; end
      3'd5: begin dx = -oy; dy = -ox; end
      3'd6: begin dx =  ox; dy = -oy; end
      default: begin dx = oy; dy = -ox; end
    endcase
    x = acx + dx;
    y = acy + dy;

    on_screen = !x[IW-1] && (x < X_LIM) && !y[IW-1] && (y < Y_LIM);

    case (clip)
      CLIP_BOTTOM: clip_ok = (y >= ybot) && (x >= xl) && (x <= xr);
      CLIP_RIGHT:  clip_ok = (x >= cx) && (y <= ybot);
      CLIP_LEFT:   clip_ok = (x <= cx) && (y <= ybot);
      default:     clip_ok = 1'b1;
    endcase

    plot_ok = on_screen && clip_ok;
    px      = x[XW-1:0];
    py      = y[YW-1:0];
  end

endmodule

// File: rtl/reuleaux_draw.sv
// Midpoint-circle shape engine: one full circle or the three clipped arcs of a
// Reuleaux triangle, one candidate pixel per clock toward the VGA plot port.
module reuleaux_draw
  import vga_draw_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic signed [XW:0]   centre_x,
  input  logic signed [YW:0]   centre_y,
  input  logic        [XW-1:0] size,
  input  logic        [CW-1:0] colour,
  output logic                 done,
  output logic        [XW-1:0] vga_x,
  output logic        [YW-1:0] vga_y,
  output logic        [CW-1:0] vga_colour,
  output logic                 vga_plot
);

  localparam int IW = ((XW > YW) ? XW : YW) + 4;
  localparam logic signed [IW-1:0] ONE = IW'(1);

  draw_state_t          state_q, state_d;
  logic                 mode_q, mode_d;
  logic signed [IW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic        [XW-1:0] sz_q, sz_d;
  logic        [CW-1:0] colour_q, colour_d;
  logic signed [IW-1:0] ty_q, ty_d, ybot_q, ybot_d, xl_q, xl_d, xr_q, xr_d;
  logic        [1:0]    arc_q, arc_d;
  logic        [2:0]    oct_q, oct_d;
  logic signed [IW-1:0] ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
  logic signed [IW-1:0] acx_q, acx_d, acy_q, acy_d;
  arc_clip_t            clip_q, clip_d;
  logic        [XW-1:0] vx_q, vx_d;
  logic        [YW-1:0] vy_q, vy_d;
  logic        [CW-1:0] vcol_q, vcol_d;
  logic                 plot_q, plot_d, done_q, done_d;

  logic signed [IW-1:0] size_s, ht_s, hb_s, half_s;
  logic signed [IW-1:0] ox_n, oy_n, crit_n;
  logic        [XW-1:0] pt_x;
  logic        [YW-1:0] pt_y;
  logic                 pt_ok;

  // Products are formed at 32 bits so size*K_HT never wraps before the divide.
  assign size_s = IW'(sz_q);
  assign ht_s   = IW'((32'(sz_q) * K_HT) / K_DEN);
  assign hb_s   = IW'((32'(sz_q) * K_HB) / K_DEN);
  assign half_s = IW'(sz_q >> 1);

  octant_point #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW), .YW(YW), .IW(IW)
  ) u_pt (
    .acx(acx_q), .acy(acy_q), .ox(ox_q), .oy(oy_q), .oct(oct_q), .clip(clip_q),
    .cx(cx_q), .ybot(ybot_q), .xl(xl_q), .xr(xr_q),
    .px(pt_x), .py(pt_y), .plot_ok(pt_ok)
  );

  always_comb begin
    state_d  = state_q;  mode_d = mode_q;  cx_d = cx_q;  cy_d = cy_q;
    sz_d     = sz_q;     colour_d = colour_q;
    ty_d     = ty_q;     ybot_d = ybot_q;  xl_d = xl_q;  xr_d = xr_q;
    arc_d    = arc_q;    oct_d = oct_q;    ox_d = ox_q;  oy_d = oy_q;
    crit_d   = crit_q;   acx_d = acx_q;    acy_d = acy_q; clip_d = clip_q;
    vx_d     = vx_q;     vy_d = vy_q;      vcol_d = vcol_q;
    plot_d   = 1'b0;
    oy_n     = oy_q + ONE;
    ox_n     = ox_q;
    crit_n   = crit_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_INIT;
          mode_d   = mode;
          cx_d     = IW'(centre_x);
          cy_d     = IW'(centre_y);
          sz_d     = size;
          colour_d = colour;
          arc_d    = 2'd0;
        end
      end
      S_INIT: begin
        ty_d    = cy_q - ht_s;
        ybot_d  = cy_q + hb_s;
        xl_d    = cx_q - half_s;
        xr_d    = cx_q + half_s;
        state_d = S_ARC_INIT;
      end
      S_ARC_INIT: begin
        ox_d   = size_s;
        oy_d   = '0;
        crit_d = ONE - size_s;
        oct_d  = 3'd0;
        if (!mode_q) begin
          acx_d = cx_q;  acy_d = cy_q;   clip_d = CLIP_NONE;
        end else if (arc_q == 2'd0) begin
          acx_d = cx_q;  acy_d = ty_q;   clip_d = CLIP_BOTTOM;
        end else if (arc_q == 2'd1) begin
          acx_d = xl_q;  acy_d = ybot_q; clip_d = CLIP_RIGHT;
        end else begin
          acx_d = xr_q;  acy_d = ybot_q; clip_d = CLIP_LEFT;
        end
        state_d = S_PLOT;
      end
      S_PLOT: begin
        vx_d   = pt_x;
        vy_d   = pt_y;
        vcol_d = colour_q;
        plot_d = pt_ok;
        oct_d  = oct_q + 3'd1;
        if (oct_q == 3'd7) state_d = S_STEP;
      end
      S_STEP: begin
        if (crit_q[IW-1] || (crit_q == '0)) begin
          crit_n = crit_q + (oy_n <<< 1) + ONE;
        end else begin
          ox_n   = ox_q - ONE;
          crit_n = crit_q + ((oy_n - ox_n) <<< 1) + ONE;
        end
        ox_d   = ox_n;
        oy_d   = oy_n;
        crit_d = crit_n;
        if (oy_n <= ox_n) begin
          state_d = S_PLOT;
        end else if (!mode_q || (arc_q == 2'd2)) begin
          state_d = S_DONE;
        end else begin
          arc_d   = arc_q + 2'd1;
          state_d = S_ARC_INIT;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  mode_q <= 1'b0;  cx_q <= '0;  cy_q <= '0;
      sz_q    <= '0;      colour_q <= '0;
      ty_q    <= '0;      ybot_q <= '0;    xl_q <= '0;  xr_q <= '0;
      arc_q   <= '0;      oct_q <= '0;     ox_q <= '0;  oy_q <= '0;
      crit_q  <= '0;      acx_q <= '0;     acy_q <= '0; clip_q <= CLIP_NONE;
      vx_q    <= '0;      vy_q <= '0;      vcol_q <= '0;
      plot_q  <= 1'b0;    done_q <= 1'b0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; cx_q <= cx_d; cy_q <= cy_d;
      sz_q    <= sz_d;    colour_q <= colour_d;
      ty_q    <= ty_d;    ybot_q <= ybot_d; xl_q <= xl_d; xr_q <= xr_d;
      arc_q   <= arc_d;   oct_q <= oct_d;   ox_q <= ox_d; oy_q <= oy_d;
      crit_q  <= crit_d;  acx_q <= acx_d;   acy_q <= acy_d; clip_q <= clip_d;
      vx_q    <= vx_d;    vy_q <= vy_d;     vcol_q <= vcol_d;
      plot_q  <= plot_d;  done_q <= done_d;
    end
  end

  assign done       = done_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vcol_q;
  assign vga_plot   = plot_q;

endmodule
